binary2onehot_stream: RTL and testbench
=======================================

Name: binary2onehot_stream

Overview:
- Streaming, registered successor to the combinational binary-to-one-hot decoder.
- Accepts binary words over a valid/ready interface and decodes each one in a run-time selectable mode: one-hot, one-cold, thermometer or inverted thermometer.
- Detects codes outside the output width and counts them in a saturating error counter.
- Sits between address/select generators and downstream per-lane enable logic, as a full-throughput register slice that breaks ready/valid timing paths.

Parameters:
- BIN_WIDTH, 4, binary input width (>= 1).
- OH_WIDTH, 2**BIN_WIDTH, decoded bus width (1 .. 2**BIN_WIDTH).
- ERR_CNT_WIDTH, 8, range-error counter width (>= 1).

Ports:
- clk  input  1  clock; all logic rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- i_binary  input  BIN_WIDTH  binary code.
- i_mode  input  2  decode mode, sampled with i_binary.
- i_valid  input  1  input word valid.
- i_ready  output  1  block can accept a word.
- o_decoded  output  OH_WIDTH  decoded word.
- o_range_err  output  1  word carried an out-of-range code (i_binary >= OH_WIDTH).
- o_valid  output  1  output word valid.
- o_ready  input  1  downstream accepts the word.
- err_clr  input  1  synchronous clear of the error counter.
- err_cnt  output  ERR_CNT_WIDTH  saturating count of out-of-range words delivered.

Behaviour:
- Single clock; one asynchronous active-low reset (reset_n); no other reset.
- Reset values: i_ready=1, o_valid=0, o_decoded=0, o_range_err=0, err_cnt=0, both buffer entries empty.
- Handshake:
  - Input transfer when i_valid && i_ready; output transfer when o_valid && o_ready.
  - o_valid, o_decoded and o_range_err are held stable while o_valid && !o_ready.
- Buffering:
  - Two-entry skid buffer (main + skid). Decode is done before storage, so both entries hold decoded data.
  - i_ready is a register output: i_ready = skid entry empty.
  - Latency: an accepted word appears on o_valid the next cycle if the main entry was empty or is being drained that cycle.
  - Sustained throughput is 1 word/clk with o_ready held high.
- Buffer states:
  - EMPTY: o_valid=0. On accept go to ONE.
  - ONE: main entry full, o_valid=1.
    - Accept and drain together: main is replaced, stay ONE.
    - Accept only: new word goes to the skid entry; go FULL with i_ready=0.
    - Drain only: go EMPTY.
  - FULL: i_ready=0. On drain, the skid word moves to main; go ONE.
  - No other transitions. Words are delivered in strict order, with no loss and no duplication.
- Decode, with b = i_binary and in-range meaning b < OH_WIDTH:
  - mode 0, one-hot: only bit b set.
  - mode 1, one-cold: only bit b clear.
  - mode 2, thermometer: bits [b:0] set.
  - mode 3, inverted thermometer: bits [OH_WIDTH-1:b] set.
- Out of range (b >= OH_WIDTH; possible only when OH_WIDTH < 2**BIN_WIDTH):
  - range_err = 1.
  - Decoded word: mode 0 all zeros; mode 1 all ones; mode 2 all ones (saturated); mode 3 all zeros.
- Error counter:
  - Increments by 1 on each output transfer with o_range_err=1 and saturates at all ones.
  - err_clr forces 0 and has priority over a same-cycle increment; that increment is lost.
- Reset mid-operation: both entries are discarded asynchronously and outputs return to reset values immediately. No word is delivered after reset release unless it is newly accepted.
- i_mode is never used while a word is buffered. A mode change takes effect from the next accepted word only.

Decomposition:
- Package binary2onehot_pkg:
  - Mode enum decode_mode_t: DEC_ONEHOT=0, DEC_ONECOLD=1, DEC_THERM=2, DEC_ITHERM=3.
  - Pure function decode(binary, mode) returning the decoded word and the range flag, parameterised through module-level widths.
- One natural sub-module: the existing combinational binary2onehot, instantiated as the one-hot core. Thermometer and cold variants are derived from its output.
- The skid buffer stays inline.

Test Plan:
- Reset, then BIN_WIDTH=4, OH_WIDTH=16, mode 0, send b=5 with o_ready=1 -> next cycle o_valid=1, o_decoded=16'h0020; same flow in mode 1 -> 16'hFFDF.
- Mode 2, b=3 -> 16'h000F; mode 3, b=3 -> 16'hFFF8; b=0 mode 2 -> 16'h0001; b=15 mode 3 -> 16'h8000.
- OH_WIDTH=10, b=12 in mode 0 -> o_decoded=10'h000, o_range_err=1, err_cnt=1 after the transfer; same in mode 2 -> 10'h3FF.
- Back-pressure: stream b=1,2,3 with o_ready=0 -> i_ready falls after 2 accepts; release o_ready -> outputs 2,4,8 (mode 0) in order, no loss or duplication.
- Saturation: ERR_CNT_WIDTH=2, deliver 5 out-of-range words -> err_cnt stays 3; err_clr together with an error transfer -> err_cnt=0.
- Assert reset_n low with the FULL state active -> o_valid=0 and i_ready=1 immediately; after release no stale word appears.

Source files
------------

// File: rtl/binary2onehot_pkg.sv
// Shared types and decode helpers for the streaming binary-to-one-hot decoder.
// Derived words are built at MAX_OH_WIDTH and sliced down by the user.
package binary2onehot_pkg;

   typedef enum logic [1:0] {
      DEC_ONEHOT  = 2'd0,
      DEC_ONECOLD = 2'd1,
      DEC_THERM   = 2'd2,
      DEC_ITHERM  = 2'd3
   } decode_mode_t;

   typedef enum logic [1:0] {
      BUF_EMPTY,
      BUF_ONE,
      BUF_FULL
   } buf_state_t;

   localparam int unsigned MAX_OH_WIDTH = 1024;

   typedef logic [MAX_OH_WIDTH-1:0] wide_word_t;

   typedef struct packed {
      wide_word_t word;
      logic       range_err;
   } decode_t;

   // An all-zero one-hot input (out of range) falls out as the saturated
   // patterns: therm -> all ones, itherm -> all zeros.
   function automatic wide_word_t from_onehot(wide_word_t onehot, decode_mode_t mode);
      wide_word_t r;
      unique case (mode)
         DEC_ONEHOT:  r = onehot;
         DEC_ONECOLD: r = ~onehot;
         DEC_THERM:   r = (onehot << 1) - wide_word_t'(1);
         DEC_ITHERM:  r = ~(onehot - wide_word_t'(1));
         default:     r = onehot;
      endcase
      return r;
   endfunction

   function automatic decode_t decode(int unsigned binary, decode_mode_t mode,
                                      int unsigned oh_width);
      decode_t d;
      d.range_err = (binary >= oh_width);
      d.word      = d.range_err ? '0 : (wide_word_t'(1) << binary);
      d.word      = from_onehot(d.word, mode);
      return d;
   endfunction

endpackage

// File: rtl/binary2onehot.sv
// Combinational binary to one-hot core; codes at or above OH_WIDTH give all zeros.
module binary2onehot #(
   parameter int unsigned BIN_WIDTH = 4,
   parameter int unsigned OH_WIDTH  = 2**BIN_WIDTH
) (
   input  logic [BIN_WIDTH-1:0] binary_i,
   output logic [OH_WIDTH-1:0]  onehot_o,
   output logic                 in_range_o
);

   always_comb begin
      onehot_o = '0;
      for (int unsigned i = 0; i < OH_WIDTH; i++) begin
         if (binary_i == BIN_WIDTH'(i)) onehot_o[i] = 1'b1;
      end
   end

   assign in_range_o = |onehot_o;

endmodule

// File: rtl/binary2onehot_stream.sv
// Registered valid/ready decoder: decode on input, two-entry skid buffer of decoded
// words, saturating counter of out-of-range words delivered downstream.
module binary2onehot_stream
   import binary2onehot_pkg::*;
#(
   parameter int unsigned BIN_WIDTH     = 4,
   parameter int unsigned OH_WIDTH      = 2**BIN_WIDTH,
   parameter int unsigned ERR_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [BIN_WIDTH-1:0]     i_binary,
   input  logic [1:0]               i_mode,
   input  logic                     i_valid,
   output logic                     i_ready,
   output logic [OH_WIDTH-1:0]      o_decoded,
   output logic                     o_range_err,
   output logic                     o_valid,
   input  logic                     o_ready,
   input  logic                     err_clr,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

   logic [OH_WIDTH-1:0]      core_onehot;
   logic                     core_in_range;
   wide_word_t               onehot_ext;
   wide_word_t               decoded_wide;
   logic [OH_WIDTH-1:0]      dec_word;
   logic                     dec_err;

   buf_state_t               state_q;
   logic                     ready_q;
   logic                     valid_q;
   logic [OH_WIDTH-1:0]      main_word_q;
   logic                     main_err_q;
   logic [OH_WIDTH-1:0]      skid_word_q;
   logic                     skid_err_q;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_d;

   logic                     in_xfer;
   logic                     out_xfer;

   binary2onehot #(
      .BIN_WIDTH (BIN_WIDTH),
      .OH_WIDTH  (OH_WIDTH)
   ) u_core (
      .binary_i   (i_binary),
      .onehot_o   (core_onehot),
      .in_range_o (core_in_range)
   );

   always_comb begin
      onehot_ext                = '0;
      onehot_ext[OH_WIDTH-1:0]  = core_onehot;
      decoded_wide              = from_onehot(onehot_ext, decode_mode_t'(i_mode));
      dec_word                  = decoded_wide[OH_WIDTH-1:0];
      dec_err                   = ~core_in_range;
   end

   if (OH_WIDTH < MAX_OH_WIDTH) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^decoded_wide[MAX_OH_WIDTH-1:OH_WIDTH];
   end

   assign in_xfer  = i_valid && ready_q;
   assign out_xfer = valid_q && o_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= BUF_EMPTY;
         ready_q     <= 1'b1;
         valid_q     <= 1'b0;
         main_word_q <= '0;
         main_err_q  <= 1'b0;
         skid_word_q <= '0;
         skid_err_q  <= 1'b0;
      end else begin
         unique case (state_q)
            BUF_EMPTY: begin
               if (in_xfer) begin
                  main_word_q <= dec_word;
                  main_err_q  <= dec_err;
                  valid_q     <= 1'b1;
                  state_q     <= BUF_ONE;
               end
            end
            BUF_ONE: begin
               if (in_xfer && out_xfer) begin
                  main_word_q <= dec_word;
                  main_err_q  <= dec_err;
               end else if (in_xfer) begin
                  skid_word_q <= dec_word;
                  skid_err_q  <= dec_err;
                  ready_q     <= 1'b0;
                  state_q     <= BUF_FULL;
               end else if (out_xfer) begin
                  valid_q     <= 1'b0;
                  state_q     <= BUF_EMPTY;
               end
            end
            BUF_FULL: begin
               if (out_xfer) begin
                  main_word_q <= skid_word_q;
                  main_err_q  <= skid_err_q;
                  ready_q     <= 1'b1;
                  state_q     <= BUF_ONE;
               end
            end
            default: begin
               valid_q <= 1'b0;
               ready_q <= 1'b1;
               state_q <= BUF_EMPTY;
            end
         endcase
      end
   end

   // Clear wins over a same-cycle increment.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_clr) begin
         err_cnt_d = '0;
      end else if (out_xfer && main_err_q && !(&err_cnt_q)) begin
         err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) err_cnt_q <= '0;
      else          err_cnt_q <= err_cnt_d;
   end

   assign i_ready     = ready_q;
   assign o_valid     = valid_q;
   assign o_decoded   = main_word_q;
   assign o_range_err = main_err_q;
   assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_binary2onehot_stream.sv
// Two instances (16-wide full range, 10-wide with a 2-bit counter) share one stimulus
// stream and are checked against a queue-based reference model every cycle.
module tb_binary2onehot_stream;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] i_binary;
   logic [1:0] i_mode;
   logic       i_valid;
   logic       o_ready;
   logic       err_clr;

   logic        rdyA, rngA, vldA;
   logic [15:0] decA;
   logic [7:0]  cntA;
   logic        rdyB, rngB, vldB;
   logic [9:0]  decB;
   logic [1:0]  cntB;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   binary2onehot_stream #(.BIN_WIDTH(4), .OH_WIDTH(16), .ERR_CNT_WIDTH(8)) dut_a (
      .clk(clk), .reset_n(reset_n), .i_binary(i_binary), .i_mode(i_mode),
      .i_valid(i_valid), .i_ready(rdyA), .o_decoded(decA), .o_range_err(rngA),
      .o_valid(vldA), .o_ready(o_ready), .err_clr(err_clr), .err_cnt(cntA));

   binary2onehot_stream #(.BIN_WIDTH(4), .OH_WIDTH(10), .ERR_CNT_WIDTH(2)) dut_b (
      .clk(clk), .reset_n(reset_n), .i_binary(i_binary), .i_mode(i_mode),
      .i_valid(i_valid), .i_ready(rdyB), .o_decoded(decB), .o_range_err(rngB),
      .o_valid(vldB), .o_ready(o_ready), .err_clr(err_clr), .err_cnt(cntB));

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode straight from the per-bit rules.
   function automatic logic [15:0] model_dec(int w, int b, int m);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < w; i++) begin
         case (m)
            0:       r[i] = (i == b);
            1:       r[i] = (i != b);
            2:       r[i] = (i <= b);
            default: r[i] = (i >= b);
         endcase
      end
      return r;
   endfunction

   typedef struct { int b; int m; } word_t;
   word_t q[$];
   int    mcntA = 0;
   int    mcntB = 0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q.delete();
         mcntA = 0;
         mcntB = 0;
      end else begin
         bit    acc, drn;
         word_t w;
         acc = i_valid && (q.size() < 2);
         drn = o_ready && (q.size() > 0);
         if (drn) w = q.pop_front();
         if (err_clr) begin
            mcntA = 0;
            mcntB = 0;
         end else if (drn) begin
            if (w.b >= 16 && mcntA < 255) mcntA++;
            if (w.b >= 10 && mcntB < 3)   mcntB++;
         end
         if (acc) q.push_back('{int'(i_binary), int'(i_mode)});
      end
   end

   always @(negedge clk) begin
      int n;
      n = q.size();
      chk("rdyA", rdyA, n < 2);
      chk("rdyB", rdyB, n < 2);
      chk("vldA", vldA, n > 0);
      chk("vldB", vldB, n > 0);
      if (n > 0) begin
         chk("decA", decA, model_dec(16, q[0].b, q[0].m));
         chk("decB", decB, model_dec(10, q[0].b, q[0].m));
         chk("rngA", rngA, q[0].b >= 16);
         chk("rngB", rngB, q[0].b >= 10);
      end
      chk("cntA", cntA, mcntA);
      chk("cntB", cntB, mcntB);
   end

   task automatic send_one(int b, int m, logic [15:0] ea, logic [9:0] eb, logic eb_rng);
      i_binary = 4'(b);
      i_mode   = 2'(m);
      i_valid  = 1'b1;
      o_ready  = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      chk("lit_vldA", vldA, 1);
      chk("lit_decA", decA, ea);
      chk("lit_decB", decB, eb);
      chk("lit_rngB", rngB, eb_rng);
      @(negedge clk);
   endtask

   initial begin
      reset_n  = 1'b0;
      i_binary = '0;
      i_mode   = '0;
      i_valid  = 1'b0;
      o_ready  = 1'b0;
      err_clr  = 1'b0;

      chk("pin_model_m0", model_dec(16, 5, 0), 16'h0020);
      chk("pin_model_m3", model_dec(10, 12, 3), 16'h0000);

      repeat (3) @(negedge clk);
      chk("rst_rdyA", rdyA, 1);  chk("rst_vldA", vldA, 0);
      chk("rst_decA", decA, 0);  chk("rst_rngA", rngA, 0);
      chk("rst_cntA", cntA, 0);  chk("rst_rdyB", rdyB, 1);
      chk("rst_vldB", vldB, 0);  chk("rst_cntB", cntB, 0);
      reset_n = 1'b1;
      @(negedge clk);

      send_one(5,  0, 16'h0020, 10'h020, 1'b0);
      send_one(5,  1, 16'hFFDF, 10'h3DF, 1'b0);
      send_one(3,  2, 16'h000F, 10'h00F, 1'b0);
      send_one(3,  3, 16'hFFF8, 10'h3F8, 1'b0);
      send_one(0,  2, 16'h0001, 10'h001, 1'b0);
      send_one(15, 3, 16'h8000, 10'h000, 1'b1);
      chk("lit_cntB_15", cntB, 1);

      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("lit_clrB", cntB, 0);
      send_one(12, 0, 16'h1000, 10'h000, 1'b1);
      chk("lit_cntB_1", cntB, 1);
      chk("lit_cntA_0", cntA, 0);
      send_one(12, 2, 16'h1FFF, 10'h3FF, 1'b1);
      chk("lit_cntB_2", cntB, 2);

      // Back-pressure: two accepts fill the buffer, third word stalls.
      o_ready  = 1'b0;
      i_mode   = 2'd0;
      i_valid  = 1'b1;
      i_binary = 4'd1;
      @(negedge clk);
      chk("bp_rdy1", rdyA, 1);
      i_binary = 4'd2;
      @(negedge clk);
      chk("bp_rdy2", rdyA, 0);
      chk("bp_out1", decA, 16'h0002);
      i_binary = 4'd3;
      o_ready  = 1'b1;
      @(negedge clk);
      chk("bp_out2", decA, 16'h0004);
      chk("bp_rdy3", rdyA, 1);
      @(negedge clk);
      i_valid = 1'b0;
      chk("bp_out3", decA, 16'h0008);
      @(negedge clk);
      chk("bp_empty", vldA, 0);

      // Saturation of the 2-bit counter.
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      i_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         i_binary = 4'(10 + k);
         i_mode   = 2'($urandom_range(0, 3));
         @(negedge clk);
      end
      i_valid = 1'b0;
      @(negedge clk);
      chk("sat_cntB", cntB, 3);
      chk("sat_cntA", cntA, 0);

      // Clear coinciding with an erroring transfer.
      o_ready  = 1'b0;
      i_valid  = 1'b1;
      i_binary = 4'd13;
      @(negedge clk);
      i_valid = 1'b0;
      chk("clr_pre_vld", vldB, 1);
      err_clr = 1'b1;
      o_ready = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("clr_xfer_cntB", cntB, 0);

      // Reset while FULL.
      o_ready  = 1'b0;
      i_valid  = 1'b1;
      i_binary = 4'd7;
      @(negedge clk);
      i_binary = 4'd9;
      @(negedge clk);
      i_valid = 1'b0;
      chk("full_rdyA", rdyA, 0);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_vldA", vldA, 0); chk("arst_rdyA", rdyA, 1);
      chk("arst_vldB", vldB, 0); chk("arst_rdyB", rdyB, 1);
      chk("arst_decA", decA, 0);
      @(negedge clk);
      reset_n = 1'b1;
      o_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_vld", vldA, 0);

      // Randomized traffic.
      repeat (3000) begin
         i_valid  = ($urandom % 10) < 7;
         i_binary = 4'($urandom_range(0, 15));
         i_mode   = 2'($urandom_range(0, 3));
         o_ready  = ($urandom % 10) < 6;
         err_clr  = ($urandom % 64) == 0;
         @(negedge clk);
      end
      i_valid = 1'b0;
      err_clr = 1'b0;
      o_ready = 1'b1;
      repeat (4) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
